data_memory_mfc: RTL and testbench
==================================

DATA_MEMORY_MFC -- requirements
Module: data_memory_mfc

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL provide parameter LATENCY, default 2, meaning cycles from request acceptance to MFC (legal 1..15).
REQ-003 SHALL have the following ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- read  input  1  read request, sampled in IDLE.
- write  input  1  write request, sampled in IDLE.
- addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
- write_data  input  32  store data.
- out_data  output  32  load data.
- MFC  output  1  memory-function-complete pulse.
- busy  output  1  high while a request is in flight.
- err  output  1  misaligned-access flag, valid with MFC.

Function
REQ-004 SHALL implement FSM states IDLE and WAIT only.
REQ-005 In IDLE, a rising edge with read=1 or write=1 SHALL accept the request: latch addr, write_data and op; load the counter with LATENCY; go to WAIT.
REQ-006 With read=1 and write=1 together, the block SHALL perform the write only.
REQ-007 In WAIT, the counter SHALL decrement each edge; on the edge where it reaches 0, the block SHALL return to IDLE.
REQ-008 For a request accepted at edge N, the block SHALL drive MFC=1 for exactly one cycle, following edge N+LATENCY.
REQ-009 The write SHALL commit to the array at edge N+LATENCY, never earlier.
REQ-010 For a read, out_data SHALL update at edge N+LATENCY and hold until the next completed read.
REQ-011 busy SHALL be 1 from edge N to edge N+LATENCY, inclusive of the WAIT state, and 0 in IDLE.
REQ-012 Requests presented while busy=1 SHALL be ignored, not queued.
REQ-013 A new request present in the MFC cycle SHALL be accepted on the following edge, giving back-to-back throughput of one access per LATENCY+1 cycles.
REQ-014 Address bits above log2(DEPTH)+1 SHALL be ignored, so accesses wrap modulo DEPTH words.
REQ-015 Inputs SHALL only be sampled at acceptance; changes during WAIT SHALL have no effect.
REQ-016 Any LATENCY outside 1..15 SHALL be clamped to 1.

Reset
REQ-017 reset=0 at a rising edge SHALL force IDLE, counter=0, MFC=0, busy=0, err=0 and out_data=0.
REQ-018 Reset during WAIT SHALL abort the access: no array write and no MFC pulse.
REQ-019 The memory array SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro MEM_ALIGN_CHECK_EN SHALL control alignment checking.
- Defined: an accepted request with addr[1:0]!=0 SHALL complete with normal MFC timing and err=1 for the MFC cycle; a write SHALL NOT modify the array; a read SHALL leave out_data unchanged.
- Undefined: addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-021 Use LATENCY=2 and DEPTH=256 unless stated. The bench SHALL cover:
- Write then read: write addr=0x10 data=0xDEADBEEF accepted at edge N -> MFC high after edge N+2 only; then read 0x10 -> out_data=0xDEADBEEF with MFC.
- Ignored mid-flight request: second write to addr=0x20 while busy=1 -> no effect; later read of 0x20 returns its prior value.
- Read/write collision and wrap: read=write=1 at addr=0x400 with data=0x12345678 -> write only, to word 0; read of 0x0 -> 0x12345678.
- Reset mid-access: reset=0 one cycle after write acceptance -> MFC never asserts, busy=0, target word unchanged.
- Misaligned access: with MEM_ALIGN_CHECK_EN defined, write addr=0x13 -> MFC=1 with err=1 and word 4 unchanged; with the macro undefined, the same write lands in word 4 and err=0.
- Back-to-back throughput: with LATENCY=1, continuous read=1 -> one MFC every 2 cycles.

Source files
------------

// File: rtl/data_memory_mfc_if.sv
// Request/response bus of the latency-programmable data memory.
// The requester drives read/write/addr/write_data; the memory answers with out_data/MFC/busy/err.
interface data_memory_mfc_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] out_data;
  logic        MFC;
  logic        busy;
  logic        err;

  modport master (
    output read, write, addr, write_data,
    input  out_data, MFC, busy, err
  );

  modport slave (
    input  read, write, addr, write_data,
    output out_data, MFC, busy, err
  );
endinterface

// File: rtl/data_memory_mfc.sv
// Single-port word memory that completes each access LATENCY cycles after acceptance with an MFC pulse.
// Optional build macro MEM_ALIGN_CHECK_EN: flag misaligned accesses with err and suppress their effect.
//
// state | meaning
// IDLE  | no access in flight, sampling read/write
// WAIT  | access latched, counter running down to completion
module data_memory_mfc #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  data_memory_mfc_if.slave bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         LAT     = (LATENCY >= 1 && LATENCY <= 15) ? LATENCY : 1;
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     out_q, out_d;
  logic            mfc_q, mfc_d;
  logic            err_q, err_d;
  logic            accept;
  logic            done;
  logic            misalign;
  logic            mem_we;
  logic            unused_addr;
  logic [31:0]     mem_q [DEPTH];

  assign accept      = (state_q == IDLE) && (bus.read || bus.write);
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] lo_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lo_q <= 2'b00;
    end else if (accept) begin
      lo_q <= bus.addr[1:0];
    end
  end

  assign misalign = |lo_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    out_d   = out_q;
    mfc_d   = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = LAT_CNT;
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.write_data;
          is_wr_d = bus.write;  // write wins when both are requested
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done    = 1'b1;
          mfc_d   = 1'b1;
          err_d   = misalign;
          if (!is_wr_q && !misalign) begin
            out_d = mem_q[idx_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = done && is_wr_q && !misalign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      out_q   <= 32'd0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      out_q   <= out_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a reset edge only blocks the pending commit.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.out_data = out_q;
  assign bus.MFC      = mfc_q;
  assign bus.busy     = (state_q == WAIT);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data_memory_mfc.sv
// Randomized scoreboard bench for data_memory_mfc: a word-array model predicts each completion,
// a monitor checks every MFC pulse against it; extra LATENCY=1 / clamped instances check throughput.
module tb_data_memory_mfc;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_memory_mfc_if bus ();
  data_memory_mfc_if ifl ();
  data_memory_mfc_if ifc ();

  data_memory_mfc #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  data_memory_mfc #(.DEPTH(16), .LATENCY(1))      u_lat1 (.clk(clk), .reset(reset), .bus(ifl));
  data_memory_mfc #(.DEPTH(16), .LATENCY(0))      u_clamp (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_out;
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Reference model: word-addressed array, address modulo DEPTH words, write wins on collision.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int acc_cyc);
    exp_t e;
    logic mis;
    int   idx;
    idx = int'((a >> 2) % DEPTH);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a % 4) != 0;
`endif
    if (wr) begin
      if (!mis) ref_mem[idx] = d;
    end else if (rd && !mis) begin
      ref_out = ref_mem[idx];
    end
    e.cyc  = acc_cyc + LAT;
    e.data = ref_out;
    e.err  = mis;
    sb.push_back(e);
  endtask

  task automatic clear_bus();
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = 32'd0; bus.write_data = 32'd0;
  endtask

  // Issue one request; jmode 0 = quiet while busy, 1 = random junk, 2 = junk write to 0x20.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int jmode);
    @(negedge clk);
    bus.read = rd; bus.write = wr; bus.addr = a; bus.write_data = d;
    @(posedge clk);
    #1;
    model(rd, wr, a, d, cyc);
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    case (jmode)
      1: begin
        bus.read = 1'($urandom); bus.write = 1'($urandom);
        bus.addr = $urandom; bus.write_data = $urandom;
      end
      2: begin
        bus.read = 1'b0; bus.write = 1'b1; bus.addr = 32'h20; bus.write_data = $urandom;
      end
      default: clear_bus();
    endcase
    repeat (LAT) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    clear_bus();
    repeat (n) @(posedge clk);
  endtask

  task automatic reset_abort(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.write = 1'b1; bus.addr = a; bus.write_data = d;
    @(posedge clk);
    @(negedge clk);
    clear_bus();
    reset = 1'b0;
    @(posedge clk);
    #1;
    ref_out = 32'd0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_mfc", {31'd0, bus.MFC}, 32'd0);
    chk("abort_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.MFC) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_mfc: MFC high with nothing pending at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("mfc_cycle", cyc, mon_e.cyc);
        chk("out_data", bus.out_data, mon_e.data);
        chk("err", {31'd0, bus.err}, {31'd0, mon_e.err});
        chk("busy_in_mfc", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        rd, wr;
    logic [31:0] a;
    int          n_mfc_l, n_mfc_c;

    clear_bus();
    ifl.read = 1'b0; ifl.write = 1'b0; ifl.addr = 32'd0; ifl.write_data = 32'd0;
    ifc.read = 1'b0; ifc.write = 1'b0; ifc.addr = 32'd0; ifc.write_data = 32'd0;
    ref_out = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_mfc", {31'd0, bus.MFC}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 0);

    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 0);
    do_req(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 2);
    do_req(1'b1, 1'b0, 32'h20, 32'd0, 0);
    do_req(1'b1, 1'b1, 32'h400, 32'h12345678, 0);
    do_req(1'b1, 1'b0, 32'h0, 32'd0, 0);
    reset_abort(32'h44, 32'h0BADF00D);
    do_req(1'b1, 1'b0, 32'h44, 32'd0, 0);
    do_req(0, 1'b1, 32'h13, 32'hA5A5A5A5, 0);
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 0);
    do_req(1'b1, 1'b0, 32'h21, 32'd0, 0);

    for (int i = 0; i < 200; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      do_req(rd, wr, a, $urandom, int'($urandom % 2));
      if ($urandom % 5 == 0) idle(int'($urandom % 3));
    end
    idle(2);

    // LATENCY=1 (explicit and clamped from 0): continuous read gives MFC after every second edge.
    @(negedge clk);
    ifl.read = 1'b1; ifl.addr = $urandom;
    ifc.read = 1'b1; ifc.addr = $urandom;
    n_mfc_l = 0;
    n_mfc_c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("tput_lat1", {31'd0, ifl.MFC}, {31'd0, (i % 2 == 0)});
      chk("tput_clamp", {31'd0, ifc.MFC}, {31'd0, (i % 2 == 0)});
      n_mfc_l += int'(ifl.MFC);
      n_mfc_c += int'(ifc.MFC);
    end
    chk("tput_lat1_count", n_mfc_l, 32'd10);
    chk("tput_clamp_count", n_mfc_c, 32'd10);
    ifl.read = 1'b0;
    ifc.read = 1'b0;

    idle(6);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
